// File: rtl/multisub_seq_ctrl.sv
// Word-serial wide subtractor: drives one (N+1)-bit slice per clock, LS word first,
// chaining the borrow through a register, and reports result, borrow, overflow and zero.

module multisub_slice #(
   parameter int unsigned SW = 4
) (
   input  logic [SW-1:0] i_x,
   input  logic [SW-1:0] i_y,
   input  logic          i_brw,
   output logic [SW-1:0] o_d,
   output logic          o_brw
);

   // Ripple-borrow subtract; the borrow out of the top bit leaves the slice.
   always_comb begin : p_ripple
      logic v_b;
      v_b = i_brw;
      o_d = '0;
      for (int i = 0; i < int'(SW); i++) begin
         o_d[i] = i_x[i] ^ i_y[i] ^ v_b;
         v_b    = (~i_x[i] & i_y[i]) | (~(i_x[i] ^ i_y[i]) & v_b);
      end
      o_brw = v_b;
   end

endmodule

module multisub_seq_ctrl #(
   parameter int unsigned N     = 3,
   parameter int unsigned WORDS = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic                       abort,
   input  logic [(N+1)*WORDS-1:0]     a,
   input  logic [(N+1)*WORDS-1:0]     b,
   input  logic                       b_in,
   output logic                       busy,
   output logic                       done,
   output logic [(N+1)*WORDS-1:0]     res,
   output logic                       b_out,
   output logic                       ovf,
   output logic                       zero
);

   localparam int unsigned SW    = N + 1;
   localparam int unsigned W     = SW * WORDS;
   localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t             r_state, w_state_nxt;
   logic [W-1:0]       r_a, w_a_nxt;
   logic [W-1:0]       r_b, w_b_nxt;
   logic               r_brw, w_brw_nxt;
   logic [IDX_W-1:0]   r_idx, w_idx_nxt;
   logic [W-1:0]       r_work, w_work_nxt;
   logic               w_busy_nxt, w_done_nxt, w_bout_nxt, w_ovf_nxt, w_zero_nxt;
   logic [W-1:0]       w_res_nxt;

   logic [SW-1:0]      w_x, w_y, w_d;
   logic               w_slice_brw;
   logic [W-1:0]       w_merged;

   assign w_x = r_a[32'(r_idx) * SW +: SW];
   assign w_y = r_b[32'(r_idx) * SW +: SW];

   multisub_slice #(.SW(SW)) u_slice (
      .i_x   (w_x),
      .i_y   (w_y),
      .i_brw (r_brw),
      .o_d   (w_d),
      .o_brw (w_slice_brw)
   );

   // Working value with the current slice result merged in.
   always_comb begin
      w_merged = r_work;
      w_merged[32'(r_idx) * SW +: SW] = w_d;
   end

   // Next-state and next-register values.
   always_comb begin
      w_state_nxt = r_state;
      w_a_nxt     = r_a;
      w_b_nxt     = r_b;
      w_brw_nxt   = r_brw;
      w_idx_nxt   = r_idx;
      w_work_nxt  = r_work;
      w_busy_nxt  = busy;
      w_done_nxt  = 1'b0;
      w_res_nxt   = res;
      w_bout_nxt  = b_out;
      w_ovf_nxt   = ovf;
      w_zero_nxt  = zero;

      unique case (r_state)
         S_IDLE: begin
            if (start && !abort) begin
               w_a_nxt     = a;
               w_b_nxt     = b;
               w_brw_nxt   = b_in;
               w_idx_nxt   = '0;
               w_work_nxt  = '0;
               w_busy_nxt  = 1'b1;
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (abort) begin
               w_busy_nxt  = 1'b0;
               w_state_nxt = S_IDLE;
            end else begin
               w_work_nxt = w_merged;
               w_brw_nxt  = w_slice_brw;
               w_idx_nxt  = r_idx + IDX_W'(1);
               if (r_idx == IDX_W'(WORDS - 1)) begin
                  w_res_nxt   = w_merged;
                  w_bout_nxt  = w_slice_brw;
                  w_ovf_nxt   = (r_a[W-1] != r_b[W-1]) && (w_merged[W-1] != r_a[W-1]);
                  w_zero_nxt  = (w_merged == '0);
                  w_busy_nxt  = 1'b0;
                  w_done_nxt  = 1'b1;
                  w_state_nxt = S_DONE;
               end
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_busy_nxt  = 1'b0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_brw   <= 1'b0;
         r_idx   <= '0;
         r_work  <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         res     <= '0;
         b_out   <= 1'b0;
         ovf     <= 1'b0;
         zero    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_a     <= w_a_nxt;
         r_b     <= w_b_nxt;
         r_brw   <= w_brw_nxt;
         r_idx   <= w_idx_nxt;
         r_work  <= w_work_nxt;
         busy    <= w_busy_nxt;
         done    <= w_done_nxt;
         res     <= w_res_nxt;
         b_out   <= w_bout_nxt;
         ovf     <= w_ovf_nxt;
         zero    <= w_zero_nxt;
      end
   end

endmodule

// File: tb/tb_multisub_seq_ctrl.sv
// Directed bench for multisub_seq_ctrl (N=3, WORDS=4): hand-computed results and
// cycle-exact handshake checks, sampled on the falling edge.

module tb_multisub_seq_ctrl;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        abort;
   logic [15:0] a;
   logic [15:0] b;
   logic        b_in;
   logic        busy;
   logic        done;
   logic [15:0] res;
   logic        b_out;
   logic        ovf;
   logic        zero;

   int n_chk;
   int n_pass;

   multisub_seq_ctrl #(.N(3), .WORDS(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .abort (abort),
      .a     (a),
      .b     (b),
      .b_in  (b_in),
      .busy  (busy),
      .done  (done),
      .res   (res),
      .b_out (b_out),
      .ovf   (ovf),
      .zero  (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // One full operation: start pulse, 4 busy cycles, done pulse with results.
   task automatic op(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                     input logic tbin, input logic [15:0] eres, input logic ebout,
                     input logic eovf, input logic ezero);
      @(negedge clk);
      a = ta; b = tb_; b_in = tbin; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk({tag, ".busy_e0"}, 32'(busy), 32'd1);
      chk({tag, ".done_e0"}, 32'(done), 32'd0);
      for (int k = 1; k < 4; k++) begin
         @(negedge clk);
         chk({tag, ".busy_run"}, 32'(busy), 32'd1);
      end
      @(negedge clk);
      chk({tag, ".done"},  32'(done),  32'd1);
      chk({tag, ".busy"},  32'(busy),  32'd0);
      chk({tag, ".res"},   32'(res),   32'(eres));
      chk({tag, ".b_out"}, 32'(b_out), 32'(ebout));
      chk({tag, ".ovf"},   32'(ovf),   32'(eovf));
      chk({tag, ".zero"},  32'(zero),  32'(ezero));
      @(negedge clk);
      chk({tag, ".done_drop"}, 32'(done), 32'd0);
   endtask

   initial begin
      int first_done;
      int second_done;
      n_chk = 0; n_pass = 0;
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; a = '0; b = '0; b_in = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst.busy", 32'(busy), 32'd0);
      chk("rst.done", 32'(done), 32'd0);
      chk("rst.res",  32'(res),  32'd0);
      chk("rst.flags", 32'({b_out, ovf, zero}), 32'd0);
      rst_n = 1'b1;

      op("basic",  16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
      op("under",  16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
      op("ovf_n",  16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
      op("ovf_p",  16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0);
      op("zero",   16'h5555, 16'h5554, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);

      // start held high: completions 6 clocks apart
      @(negedge clk);
      a = 16'h0003; b = 16'h0001; b_in = 1'b0; start = 1'b1;
      first_done = -1; second_done = -1;
      for (int k = 1; k <= 11; k++) begin
         @(negedge clk);
         if (done && first_done < 0) first_done = k;
         else if (done && second_done < 0) second_done = k;
      end
      start = 1'b0;
      chk("hold.first_done", 32'(first_done), 32'd5);
      chk("hold.period", 32'(second_done - first_done), 32'd6);
      chk("hold.res", 32'(res), 32'h0002);
      repeat (2) @(negedge clk);
      chk("hold.idle_busy", 32'(busy), 32'd0);

      // start pulsed mid-RUN with new operands is ignored
      @(negedge clk);
      a = 16'h00F0; b = 16'h000F; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      a = 16'hFFFF; b = 16'h0000; b_in = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      chk("midstart.done", 32'(done), 32'd1);
      chk("midstart.res", 32'(res), 32'h00E1);
      repeat (3) @(negedge clk);
      chk("midstart.no_second", 32'(busy | done), 32'd0);

      // start together with abort in IDLE: abort wins
      @(negedge clk);
      b_in = 1'b0; start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      chk("idle_abort.busy", 32'(busy), 32'd0);

      // abort on the 2nd RUN edge
      a = 16'h1111; b = 16'h0001; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort.busy", 32'(busy), 32'd0);
      begin
         int saw_done;
         saw_done = 0;
         for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (done) saw_done = 1;
         end
         chk("abort.no_done", 32'(saw_done), 32'd0);
      end
      chk("abort.res_kept", 32'(res), 32'h00E1);

      // asynchronous reset mid-RUN
      @(negedge clk);
      a = 16'h2222; b = 16'h0001; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst.busy", 32'(busy), 32'd0);
      chk("arst.done", 32'(done), 32'd0);
      chk("arst.res",  32'(res),  32'd0);
      chk("arst.flags", 32'({b_out, ovf, zero}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      op("post_rst", 16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
